// File: rtl/fetch_decode_buffer.sv
// IF/ID pipeline register between fetch and decode.
// Registers the fetched 16-bit word with its PC and joins two-word
// instructions (opcode word followed by an immediate word) into one decode
// packet. Stall holds all state. Flush replaces the contents with a NOP
// bubble. Every output is driven straight from a flop.
module fetch_decode_buffer #(
  parameter int          PC_WIDTH     = 32,
  parameter int          IMM_FLAG_BIT = 12,
  parameter logic [15:0] NOP_WORD     = 16'h0000
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [15:0]         i_instr,
  input  logic [PC_WIDTH-1:0] i_pc,
  input  logic                i_valid,
  input  logic                i_stall,
  input  logic                i_flush,
  output logic [15:0]         o_instr,
  output logic [15:0]         o_imm,
  output logic [PC_WIDTH-1:0] o_pc,
  output logic                o_valid,
  output logic                o_wait_imm
);

  typedef enum logic {
    IDLE,
    WAIT_IMM
  } state_t;

  state_t                state, state_next;
  logic [15:0]           instr_q, instr_next;
  logic [15:0]           imm_q, imm_next;
  logic [PC_WIDTH-1:0]   pc_q, pc_next;
  logic                  valid_q, valid_next;
  logic [15:0]           held_instr, held_instr_next;
  logic [PC_WIDTH-1:0]   held_pc, held_pc_next;

  // Next-state and next-output logic. Flush has priority over stall, and
  // stall has priority over a normal update. Every value holds by default.
  always_comb begin
    state_next      = state;
    instr_next      = instr_q;
    imm_next        = imm_q;
    pc_next         = pc_q;
    valid_next      = valid_q;
    held_instr_next = held_instr;
    held_pc_next    = held_pc;

    if (i_flush) begin
      state_next      = IDLE;
      instr_next      = NOP_WORD;
      imm_next        = 16'h0000;
      pc_next         = '0;
      valid_next      = 1'b0;
      held_instr_next = 16'h0000;
      held_pc_next    = '0;
    end else if (!i_stall) begin
      // Start from a bubble. The cases below overwrite it when a packet is completed.
      instr_next = NOP_WORD;
      imm_next   = 16'h0000;
      pc_next    = '0;
      valid_next = 1'b0;
      case (state)
        IDLE: begin
          if (i_valid) begin
            if (i_instr[IMM_FLAG_BIT]) begin
              held_instr_next = i_instr;
              held_pc_next    = i_pc;
              state_next      = WAIT_IMM;
            end else begin
              instr_next = i_instr;
              pc_next    = i_pc;
              valid_next = 1'b1;
            end
          end
        end
        WAIT_IMM: begin
          // The immediate word is taken whole. Its flag bit carries no meaning here.
          if (i_valid) begin
            instr_next = held_instr;
            imm_next   = i_instr;
            pc_next    = held_pc;
            valid_next = 1'b1;
            state_next = IDLE;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // State and output registers. Reset returns the buffer to an empty bubble.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= IDLE;
      instr_q    <= NOP_WORD;
      imm_q      <= 16'h0000;
      pc_q       <= '0;
      valid_q    <= 1'b0;
      held_instr <= 16'h0000;
      held_pc    <= '0;
    end else begin
      state      <= state_next;
      instr_q    <= instr_next;
      imm_q      <= imm_next;
      pc_q       <= pc_next;
      valid_q    <= valid_next;
      held_instr <= held_instr_next;
      held_pc    <= held_pc_next;
    end
  end

  assign o_instr    = instr_q;
  assign o_imm      = imm_q;
  assign o_pc       = pc_q;
  assign o_valid    = valid_q;
  assign o_wait_imm = (state == WAIT_IMM);

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Scoreboard testbench for fetch_decode_buffer.
// Stimulus drives inputs on the falling edge. A reference model then pushes
// the packet expected after the next rising edge. A monitor pops one
// expectation per cycle and compares it shortly after the rising edge.
module tb_fetch_decode_buffer;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] imm;
    logic [31:0] pc;
    logic        valid;
    logic        wait_imm;
  } pkt_t;

  typedef struct packed {
    logic [15:0] instr;
    logic [31:0] pc;
  } held_t;

  logic        i_clk;
  logic        i_reset;
  logic [15:0] i_instr;
  logic [31:0] i_pc;
  logic        i_valid;
  logic        i_stall;
  logic        i_flush;
  logic [15:0] o_instr;
  logic [15:0] o_imm;
  logic [31:0] o_pc;
  logic        o_valid;
  logic        o_wait_imm;

  int    tests;
  int    failed;
  pkt_t  expQ[$];
  held_t heldQ[$];
  pkt_t  lastOut;
  pkt_t  bubble;
  logic [31:0] pcCnt;

  fetch_decode_buffer #(
    .PC_WIDTH(32),
    .IMM_FLAG_BIT(12),
    .NOP_WORD(16'h0000)
  ) dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_instr(i_instr),
    .i_pc(i_pc),
    .i_valid(i_valid),
    .i_stall(i_stall),
    .i_flush(i_flush),
    .o_instr(o_instr),
    .o_imm(o_imm),
    .o_pc(o_pc),
    .o_valid(o_valid),
    .o_wait_imm(o_wait_imm)
  );

  // Free-running clock with a 10-time-unit period.
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Compare the live DUT outputs against one expected packet.
  task automatic checkOutput(input string name, input pkt_t e);
    tests++;
    if (o_instr !== e.instr || o_imm !== e.imm || o_pc !== e.pc ||
        o_valid !== e.valid || o_wait_imm !== e.wait_imm) begin
      failed++;
      $display("[TB] FAIL %s @%0t: got instr=%h imm=%h pc=%h valid=%b wait=%b, expected instr=%h imm=%h pc=%h valid=%b wait=%b",
               name, $time, o_instr, o_imm, o_pc, o_valid, o_wait_imm,
               e.instr, e.imm, e.pc, e.valid, e.wait_imm);
    end
  endtask

  // Reference model. An empty heldQ means the buffer is waiting for an
  // opcode word. One entry means an opcode word is waiting for its immediate.
  task automatic modelReset();
    heldQ.delete();
    lastOut = bubble;
  endtask

  task automatic modelStep(input logic v, input logic [15:0] w, input logic [31:0] pc,
                           input logic stall, input logic flush);
    pkt_t  nxt;
    held_t h;
    nxt = bubble;
    if (flush) begin
      heldQ.delete();
    end else if (stall) begin
      nxt = lastOut;
    end else if (v) begin
      if (heldQ.size() == 0) begin
        if (w[12]) begin
          h.instr = w;
          h.pc    = pc;
          heldQ.push_back(h);
        end else begin
          nxt.instr = w;
          nxt.pc    = pc;
          nxt.valid = 1'b1;
        end
      end else begin
        h = heldQ.pop_front();
        nxt.instr = h.instr;
        nxt.imm   = w;
        nxt.pc    = h.pc;
        nxt.valid = 1'b1;
      end
    end
    nxt.wait_imm = (heldQ.size() != 0);
    lastOut = nxt;
    expQ.push_back(nxt);
  endtask

  // Drive one cycle of inputs on the falling edge and record the expected result.
  task automatic applyStimulus(input logic v, input logic [15:0] w, input logic [31:0] pc,
                               input logic stall, input logic flush);
    @(negedge i_clk);
    i_valid = v;
    i_instr = w;
    i_pc    = pc;
    i_stall = stall;
    i_flush = flush;
    modelStep(v, w, pc, stall, flush);
  endtask

  // Assert reset partway through a cycle and check that the outputs clear without waiting for a clock edge.
  task automatic doReset(input string name);
    @(posedge i_clk);
    #2;
    i_reset = 1'b1;
    #1;
    checkOutput(name, bubble);
    modelReset();
    #1;
    i_reset = 1'b0;
  endtask

  // Monitor: one expected packet is consumed just after each rising edge.
  initial begin
    pkt_t e;
    forever begin
      @(posedge i_clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("cycle", e);
      end
    end
  end

  initial begin
    tests   = 0;
    failed  = 0;
    bubble  = '0;
    lastOut = '0;
    i_reset = 1'b1;
    i_instr = 16'h0;
    i_pc    = 32'h0;
    i_valid = 1'b0;
    i_stall = 1'b0;
    i_flush = 1'b0;
    #22;
    checkOutput("reset_state", bubble);
    modelReset();
    #1;
    i_reset = 1'b0;

    // Back-to-back stream of 1234 then 2001.
    applyStimulus(1, 16'h1234, 32'h10, 0, 0);
    applyStimulus(1, 16'h2001, 32'h11, 0, 0);
    applyStimulus(1, 16'h0042, 32'h12, 0, 0);
    applyStimulus(0, 16'h0000, 32'h0, 0, 0);

    // Two-word instruction 1800 with immediate BEEF.
    applyStimulus(1, 16'h1800, 32'h20, 0, 0);
    applyStimulus(1, 16'hBEEF, 32'h21, 0, 0);

    // One idle cycle between the opcode word and its immediate.
    applyStimulus(1, 16'h1A5A, 32'h30, 0, 0);
    applyStimulus(0, 16'h7777, 32'h31, 0, 0);
    applyStimulus(1, 16'h1111, 32'h32, 0, 0);

    // Hold a valid packet for three stalled cycles while new words are offered.
    applyStimulus(1, 16'h0123, 32'h40, 0, 0);
    applyStimulus(1, 16'h0999, 32'h41, 1, 0);
    applyStimulus(1, 16'h1888, 32'h42, 1, 0);
    applyStimulus(1, 16'h0555, 32'h43, 1, 0);
    applyStimulus(1, 16'h0456, 32'h44, 0, 0);

    // Flush while waiting for an immediate, then a one-word instruction.
    applyStimulus(1, 16'h1800, 32'h50, 0, 0);
    applyStimulus(1, 16'hBEEF, 32'h51, 0, 1);
    applyStimulus(1, 16'h0042, 32'h52, 0, 0);

    // Flush and stall together while waiting for an immediate.
    applyStimulus(1, 16'h1800, 32'h60, 0, 0);
    applyStimulus(1, 16'hCAFE, 32'h61, 1, 1);
    applyStimulus(1, 16'h0077, 32'h62, 0, 0);

    // Reset while waiting for an immediate discards the held opcode.
    applyStimulus(1, 16'h1F00, 32'h70, 0, 0);
    doReset("reset_mid_wait");
    applyStimulus(1, 16'h0042, 32'h71, 0, 0);

    // Randomized traffic.
    pcCnt = 32'h100;
    for (int i = 0; i < 400; i++) begin
      logic        v, st, fl;
      logic [15:0] w;
      v  = ($urandom_range(0, 3) != 0);
      w  = 16'($urandom);
      w[12] = ($urandom_range(0, 9) < 4);
      st = ($urandom_range(0, 4) == 0);
      fl = ($urandom_range(0, 11) == 0);
      applyStimulus(v, w, pcCnt, st, fl);
      if (v && !st) pcCnt = pcCnt + 1;
      if (i % 131 == 70) doReset("reset_random");
    end

    // Let the final expectations drain, then confirm the scoreboard is empty.
    applyStimulus(0, 16'h0, 32'h0, 0, 0);
    @(posedge i_clk);
    @(posedge i_clk);
    #2;
    tests++;
    if (expQ.size() != 0) begin
      failed++;
      $display("[TB] FAIL queue_drain: %0d entries left, expected 0", expQ.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
